// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//
// Scoring stage that sits after the pattern lanes. It turns per-lane hit/miss
// levels into single-cycle events by edge detection. It tracks the consecutive
// hit combo and the multiplier derived from it. It queues the earned points and
// feeds them one per cycle into a 5-digit packed-BCD score that drives placar.
//
// Optional feature: define HIGH_SCORE_EN to add a high-score register.
// That build adds the hi_display / new_record outputs.
//
// Ports
//   CLOCK_25    in   1      system clock, rising edge
//   reset       in   1      synchronous active-high reset, clears everything
//   clear       in   1      synchronous new-game clear (keeps high score)
//   hit         in   LANES  per-lane hit level; each rising edge is one hit
//   miss        in   LANES  per-lane miss level; each rising edge is one miss
//   display     out  20     score as 5 packed BCD digits
//   combo       out  8      consecutive-hit count, saturating at 255
//   mult        out  3      current multiplier, 1..MULT_MAX
//   busy        out  1      queued points not yet applied to the score
//   saturated   out  1      sticky, score has reached 99999
//   hi_display  out  20     (HIGH_SCORE_EN) best score seen since reset
//   new_record  out  1      (HIGH_SCORE_EN) sticky, score beat hi_display
// -----------------------------------------------------------------------------
module score_keeper #(
    parameter int LANES      = 3,
    parameter int COMBO_STEP = 10,
    parameter int MULT_MAX   = 4
) (
    input  logic             CLOCK_25,
    input  logic             reset,
    input  logic             clear,
    input  logic [LANES-1:0] hit,
    input  logic [LANES-1:0] miss,
    output logic [19:0]      display,
    output logic [7:0]       combo,
    output logic [2:0]       mult,
    output logic             busy,
    output logic             saturated
`ifdef HIGH_SCORE_EN
    ,
    output logic [19:0]      hi_display,
    output logic             new_record
`endif
);

    typedef enum logic [1:0] {IDLE, COUNT, SAT} state_t;

    localparam logic [19:0] BCD_MAX = 20'h99999;

    state_t           state_q, state_d;
    logic [LANES-1:0] hit_q, miss_q;
    logic [7:0]       pending_q, pending_d;
    logic [19:0]      display_q, display_d;
    logic [7:0]       combo_q, combo_d;
    logic [3:0]       nh, nm;
    logic [7:0]       step_idx;
    logic [9:0]       pending_sum;
    logic [8:0]       combo_sum;
    logic             consume;

    function automatic logic [3:0] popcount(input logic [LANES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    // Ripple a +1 through the BCD digits; a 9 wraps to 0 and carries on.
    function automatic logic [19:0] bcd_inc(input logic [19:0] v);
        logic [19:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 5; d++) begin
            if (carry) begin
                if (v[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Datapath: edge counts, multiplier, next pending / combo / score.
    always_comb begin
        // NOTE: every signal gets a value before any branch, so no latch is inferred.
        nh = popcount(hit & ~hit_q);
        nm = popcount(miss & ~miss_q);

        step_idx = combo_q / 8'(COMBO_STEP);
        if (step_idx > 8'(MULT_MAX - 1)) mult = 3'(MULT_MAX);
        else                             mult = 3'(step_idx) + 3'd1;

        // Points use the multiplier from the combo before this edge's update.
        pending_sum = 10'(pending_q) + 10'(nh) * 10'(mult) - 10'(consume);
        pending_d   = (pending_sum > 10'd255) ? 8'hFF : pending_sum[7:0];

        combo_sum = 9'(combo_q) + 9'(nh);
        if (nm != 4'd0)              combo_d = '0;  // a miss wins over same-cycle hits
        else if (combo_sum > 9'd255) combo_d = 8'hFF;
        else                         combo_d = combo_sum[7:0];

        display_d = consume ? bcd_inc(display_q) : display_q;
    end

    // FSM next state. COUNT mirrors "points queued". SAT is entered on the
    // edge the score lands on 99999, so the engine never wraps past it.
    always_comb begin
        state_d = state_q;
        if (state_q == SAT || display_d == BCD_MAX) state_d = SAT;
        else if (pending_d != 8'd0)                 state_d = COUNT;
        else                                        state_d = IDLE;
    end

    // FSM outputs.
    always_comb begin
        consume   = (state_q == COUNT);
        busy      = (state_q == COUNT);
        saturated = (state_q == SAT);
    end

    // State register and datapath registers.
    always_ff @(posedge CLOCK_25) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset || clear) begin
            state_q   <= IDLE;
            hit_q     <= '0;
            miss_q    <= '0;
            pending_q <= '0;
            display_q <= '0;
            combo_q   <= '0;
        end else begin
            state_q   <= state_d;
            hit_q     <= hit;
            miss_q    <= miss;
            pending_q <= (state_d == SAT) ? 8'd0 : pending_d;
            display_q <= display_d;
            combo_q   <= combo_d;
        end
    end

    assign display = display_q;
    assign combo   = combo_q;

`ifdef HIGH_SCORE_EN
    logic [19:0] hi_q;
    logic        record_q;

    // Valid BCD orders the same as binary, so a plain compare suffices.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            hi_q     <= '0;
            record_q <= 1'b0;
        end else if (clear) begin
            record_q <= 1'b0;
        end else if (display_q > hi_q) begin
            hi_q     <= display_q;
            record_q <= 1'b1;
        end
    end

    assign hi_display = hi_q;
    assign new_record = record_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

    logic        CLOCK_25 = 1'b0;
    logic        reset;
    logic        clear;
    logic [2:0]  hit;
    logic [2:0]  miss;
    logic [19:0] display;
    logic [7:0]  combo;
    logic [2:0]  mult;
    logic        busy;
    logic        saturated;
`ifdef HIGH_SCORE_EN
    logic [19:0] hi_display;
    logic        new_record;
`endif

    int tests    = 0;
    int failures = 0;
    int busy_cycles;

    score_keeper #(.LANES(3), .COMBO_STEP(10), .MULT_MAX(4)) dut (
        .CLOCK_25  (CLOCK_25),
        .reset     (reset),
        .clear     (clear),
        .hit       (hit),
        .miss      (miss),
        .display   (display),
        .combo     (combo),
        .mult      (mult),
        .busy      (busy),
        .saturated (saturated)
`ifdef HIGH_SCORE_EN
        ,
        .hi_display(hi_display),
        .new_record(new_record)
`endif
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    initial begin
        #400us;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_25);
    endtask

    task automatic pulse_hit(input logic [2:0] lanes);
        hit = lanes;
        tick();
        hit = '0;
        tick();
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) pulse_hit(3'b001);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int          t;
        r = '0;
        t = v;
        for (int d = 0; d < 5; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    initial begin
        // Reset with hit[0] already high: its rise must count on the first free edge.
        reset = 1'b1; clear = 1'b0; hit = 3'b001; miss = '0;
        tick(); tick();
        check("rst_display", display, 32'h0);
        check("rst_combo", combo, 32'd0);
        check("rst_mult", mult, 32'd1);
        check("rst_busy", busy, 32'd0);
        check("rst_sat", saturated, 32'd0);

        // 1: single rise -> pending at edge k, display +1 at k+1.
        reset = 1'b0;
        tick();
        check("t1_busy_k", busy, 32'd1);
        check("t1_disp_k", display, 32'h0);
        check("t1_combo", combo, 32'd1);
        check("t1_mult", mult, 32'd1);
        hit = '0;
        tick();
        check("t1_disp_k1", display, 32'h00001);
        check("t1_busy_k1", busy, 32'd0);
        tick();
        check("t1_busy_k2", busy, 32'd0);

        // 2: ten hits -> combo 10, mult 2; the 11th hit is worth 2.
        hits(9);
        wait_idle(20);
        check("t2_disp10", display, 32'h00010);
        check("t2_combo10", combo, 32'd10);
        check("t2_mult2", mult, 32'd2);
        hits(1);
        wait_idle(20);
        check("t2_disp12", display, 32'h00012);

        // 3: build combo 25 (12 + 9*2 + 5*3 = 45), then preset score to 5 for a carry ramp.
        hits(14);
        wait_idle(20);
        check("t3_disp45", display, 32'h00045);
        check("t3_combo25", combo, 32'd25);
        check("t3_mult3", mult, 32'd3);
        dut.display_q = 20'h00005;
        hit = 3'b111;
        tick();
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        check("t3_disp_k", display, 32'h00005);
        check("t3_combo28", combo, 32'd28);
        hit = '0;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (busy === 1'b1) busy_cycles++;
            check($sformatf("t3_ramp%0d", j), display, 32'(to_bcd(5 + j)));
        end
        check("t3_busy_cycles", busy_cycles, 32'd9);
        check("t3_idle", busy, 32'd0);

        // 4: combo 15, miss and hit on the same edge -> +2, combo cleared.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_clr_disp", display, 32'h0);
        check("t4_clr_combo", combo, 32'd0);
        hits(15);
        wait_idle(20);
        check("t4_disp20", display, 32'h00020);
        check("t4_combo15", combo, 32'd15);
        hit = 3'b001; miss = 3'b010;
        tick();
        hit = '0; miss = '0;
        check("t4_combo0", combo, 32'd0);
        check("t4_mult1", mult, 32'd1);
        wait_idle(20);
        check("t4_disp22", display, 32'h00022);

        // 5: combo 30 (22 + 10 + 20 + 30 = 82), then saturate from 99997.
        hits(30);
        wait_idle(20);
        check("t5_disp82", display, 32'h00082);
        check("t5_mult4", mult, 32'd4);
        dut.display_q = 20'h99997;
        hit = 3'b111;
        tick();
        hit = '0;
        check("t5_pend12", dut.pending_q, 32'd12);
        tick();
        check("t5_disp98", display, 32'h99998);
        check("t5_sat_lo", saturated, 32'd0);
        tick();
        check("t5_disp99", display, 32'h99999);
        check("t5_sat", saturated, 32'd1);
        check("t5_busy0", busy, 32'd0);
        check("t5_pend0", dut.pending_q, 32'd0);
        pulse_hit(3'b111);
        tick();
        check("t5_hold_disp", display, 32'h99999);
        check("t5_hold_pend", dut.pending_q, 32'd0);
        check("t5_hold_sat", saturated, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_clr_disp", display, 32'h0);
        check("t5_clr_sat", saturated, 32'd0);

        // 6: fresh reset, reach 42 (10 + 20 + 4*3), clear, then reset mid-COUNT.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hits(24);
        wait_idle(20);
        tick();
        check("t6_disp42", display, 32'h00042);
`ifdef HIGH_SCORE_EN
        check("t6_hi42", hi_display, 32'h00042);
        check("t6_rec1", new_record, 32'd1);
`endif
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t6_clr_disp", display, 32'h0);
`ifdef HIGH_SCORE_EN
        check("t6_clr_hi", hi_display, 32'h00042);
        check("t6_clr_rec", new_record, 32'd0);
`endif
        hit = 3'b111;
        tick();
        hit = '0;
        tick();
        check("t6_mid_disp", display, 32'h00001);
        check("t6_mid_busy", busy, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_disp", display, 32'h0);
        check("t6_rst_combo", combo, 32'd0);
        check("t6_rst_mult", mult, 32'd1);
        check("t6_rst_busy", busy, 32'd0);
        check("t6_rst_sat", saturated, 32'd0);
        check("t6_rst_pend", dut.pending_q, 32'd0);
`ifdef HIGH_SCORE_EN
        check("t6_rst_hi", hi_display, 32'h0);
        check("t6_rst_rec", new_record, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
